// File: rtl/regfile_writeback_arbiter_pkg.sv
// Shared defaults and helpers for the register-file writeback arbiter.
// Every other file in this slice imports this package.
package regfile_writeback_arbiter_pkg;

    localparam int NUM_REQ_DEF = 3;
    localparam int XLEN_DEF    = 32;
    localparam int ADDR_W_DEF  = 5;

    // Round-robin index arithmetic; used by the arbiter search and the pointer update.
    function automatic int wrap_idx(input int i, input int n);
        return i % n;
    endfunction

endpackage

// File: rtl/regfile_writeback_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps modulo N.
// Produces a one-hot grant, the granted index and an any-grant flag.
module rr_arbiter
    import regfile_writeback_arbiter_pkg::*;
#(
    parameter  int N     = 3,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_grant
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any_grant && req[wrap_idx(int'(ptr) + k, N)]) begin
                grant[wrap_idx(int'(ptr) + k, N)] = 1'b1;
                grant_idx = IDX_W'(wrap_idx(int'(ptr) + k, N));
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Shares the register file write port among NUM_REQ writeback sources and
// tracks outstanding destinations in a busy scoreboard queried by decode.
module regfile_writeback_arbiter
    import regfile_writeback_arbiter_pkg::*;
#(
    parameter  int NUM_REQ   = NUM_REQ_DEF,
    parameter  int XLEN      = XLEN_DEF,
    parameter  int ADDR_W    = ADDR_W_DEF,
    parameter  int ZERO_HARD = 1,
    localparam int IDX_W     = $clog2(NUM_REQ),
    localparam int NUM_REGS  = 2 ** ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*XLEN-1:0]   req_data,
    input  logic                      rsv_valid,
    input  logic [ADDR_W-1:0]         rsv_addr,
    input  logic [ADDR_W-1:0]         query_addr_0,
    input  logic [ADDR_W-1:0]         query_addr_1,
    output logic                      query_busy_0,
    output logic                      query_busy_1,
    output logic                      wb_write_enable,
    output logic [ADDR_W-1:0]         wb_write_address,
    output logic [XLEN-1:0]           wb_write_data
);

    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    grant_idx;
    logic [IDX_W-1:0]    rr_ptr;
    logic                any_grant;
    logic [ADDR_W-1:0]   sel_addr;
    logic [XLEN-1:0]     sel_data;
    logic                zero_hit;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;

    rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign req_ready = grant;

    // Grant is one-hot, so OR-ing the masked slices selects the winner.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
                sel_data = sel_data | req_data[i*XLEN +: XLEN];
            end
        end
    end

    assign zero_hit = (ZERO_HARD != 0) && (sel_addr == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (any_grant) begin
            rr_ptr <= IDX_W'(wrap_idx(int'(grant_idx) + 1, NUM_REQ));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_write_enable  <= 1'b0;
            wb_write_address <= '0;
            wb_write_data    <= '0;
        end else begin
            wb_write_enable <= any_grant && !zero_hit;
            if (any_grant) begin
                wb_write_address <= sel_addr;
                wb_write_data    <= sel_data;
            end
        end
    end

    // Reserve is applied after the commit clear so a newer producer keeps ownership.
    always_comb begin
        busy_next = busy;
        if (wb_write_enable) begin
            busy_next[wb_write_address] = 1'b0;
        end
        if (rsv_valid) begin
            busy_next[rsv_addr] = 1'b1;
        end
        if (ZERO_HARD != 0) begin
            busy_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign query_busy_0 = busy[query_addr_0] && !((ZERO_HARD != 0) && (query_addr_0 == '0));
    assign query_busy_1 = busy[query_addr_1] && !((ZERO_HARD != 0) && (query_addr_1 == '0));

endmodule
